regfile_mp_bypass: RTL and testbench

//  Parametrised multi-port register file for the MIPS datapath.
//  - Replaces the single-write/two-read file.
//  - Two write ports (ALU/mem writeback) with deterministic priority.
//  - NUM_RD combinational read ports with same-cycle write bypass.
//  - Hardwired zero register.
//  - Per-register pending scoreboard, used by issue logic to stall on RAW hazards.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_rd_port.sv | 49 ++++
 rtl/regfile_mp_bypass.sv | 109 ++++++++++
 tb/tb_regfile_mp_bypass.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
// Write-port structs carry maximum-width fields so one type serves every parameterisation.
package regfile_pkg;

  localparam int RF_DATA_W     = 32;
  localparam int RF_ADDR_W     = 5;
  localparam int RF_DATA_W_MAX = 64;
  localparam int RF_ADDR_W_MAX = 8;

  localparam logic [RF_ADDR_W_MAX-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                     en;
    logic [RF_ADDR_W_MAX-1:0] addr;
    logic [RF_DATA_W_MAX-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: write bypass, zero-register masking and
// pending masking.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W  = RF_DATA_W,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int DEPTH   = 1 << ADDR_W,
  parameter int ZERO_R0 = 1
) (
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DEPTH*DATA_W-1:0] mem_flat,
  input  logic [DEPTH-1:0]        pending,
  input  rf_wr_t                  wr0,
  input  rf_wr_t                  wr1,
  output logic [DATA_W-1:0]       data,
  output logic                    pend
);

  localparam bit ZERO_EN = (ZERO_R0 != 0);

  logic hit0;
  logic hit1;
  logic is_zero;
  logic unused_wr;

  // Upper bits of the max-width struct fields are don't-care at this width.
  assign unused_wr = ^{wr0.addr, wr0.data, wr1.addr, wr1.data};

  assign hit0    = wr0.en && (wr0.addr[ADDR_W-1:0] == addr);
  assign hit1    = wr1.en && (wr1.addr[ADDR_W-1:0] == addr);
  assign is_zero = ZERO_EN && (addr == REG_ZERO[ADDR_W-1:0]);

  always_comb begin
    data = '0;
    pend = 1'b0;
    if (!is_zero) begin
      if (hit1)
        data = wr1.data[DATA_W-1:0];
      else if (hit0)
        data = wr0.data[DATA_W-1:0];
      else
        data = mem_flat[addr*DATA_W +: DATA_W];
      // A same-cycle write supplies the value through the bypass, so no stall.
      pend = pending[addr] & ~(hit0 | hit1);
    end
  end

endmodule

// File: rtl/regfile_mp_bypass.sv
// Two-write, NUM_RD-read register file with same-cycle bypass, hardwired
// zero register and per-register pending scoreboard for RAW stalls.
module regfile_mp_bypass
  import regfile_pkg::*;
#(
  parameter int DATA_W  = RF_DATA_W,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int NUM_RD  = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     sb_set_en,
  input  logic [ADDR_W-1:0]        sb_set_addr
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam bit ZERO_EN = (ZERO_R0 != 0);

  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DEPTH*DATA_W-1:0] mem_flat;
  logic [DEPTH-1:0]        pending;
  logic [DEPTH-1:0]        pending_nxt;
  rf_wr_t                  wr0_s;
  rf_wr_t                  wr1_s;
  logic                    sb_eff;

  // Gating with rst_n keeps a write held during reset from leaking onto
  // the read ports through the bypass.
  always_comb begin
    wr0_s           = '0;
    wr0_s.en        = wr0_en & rst_n &
                      ~(ZERO_EN && (wr0_addr == REG_ZERO[ADDR_W-1:0]));
    wr0_s.addr[ADDR_W-1:0] = wr0_addr;
    wr0_s.data[DATA_W-1:0] = wr0_data;

    wr1_s           = '0;
    wr1_s.en        = wr1_en & rst_n &
                      ~(ZERO_EN && (wr1_addr == REG_ZERO[ADDR_W-1:0]));
    wr1_s.addr[ADDR_W-1:0] = wr1_addr;
    wr1_s.data[DATA_W-1:0] = wr1_data;
  end

  assign sb_eff = sb_set_en &
                  ~(ZERO_EN && (sb_set_addr == REG_ZERO[ADDR_W-1:0]));

  // Port 1 is assigned last so it wins an address collision.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (wr0_s.en)
        mem[wr0_s.addr[ADDR_W-1:0]] <= wr0_s.data[DATA_W-1:0];
      if (wr1_s.en)
        mem[wr1_s.addr[ADDR_W-1:0]] <= wr1_s.data[DATA_W-1:0];
    end
  end

  // Set is applied after clear: a newly issued producer outranks the retiring one.
  always_comb begin
    pending_nxt = pending;
    for (int i = 0; i < DEPTH; i++) begin
      if ((wr0_s.en && (wr0_s.addr[ADDR_W-1:0] == ADDR_W'(i))) ||
          (wr1_s.en && (wr1_s.addr[ADDR_W-1:0] == ADDR_W'(i))))
        pending_nxt[i] = 1'b0;
      if (sb_eff && (sb_set_addr == ADDR_W'(i)))
        pending_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)
      pending <= '0;
    else
      pending <= pending_nxt;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign mem_flat[g*DATA_W +: DATA_W] = mem[g];
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .DEPTH   (DEPTH),
      .ZERO_R0 (ZERO_R0)
    ) u_rd (
      .addr     (rd_addr[k*ADDR_W +: ADDR_W]),
      .mem_flat (mem_flat),
      .pending  (pending),
      .wr0      (wr0_s),
      .wr1      (wr1_s),
      .data     (rd_data[k*DATA_W +: DATA_W]),
      .pend     (rd_pending[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp_bypass.sv
// Scoreboard bench for regfile_mp_bypass: a behavioural model predicts each
// cycle's read results, which are queued at drive time and compared mid-cycle.
module tb_regfile_mp_bypass;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 1 << AW;

  logic               clock = 1'b0;
  logic               rst_n;
  logic               wr0_en, wr1_en, sb_set_en;
  logic [AW-1:0]      wr0_addr, wr1_addr, sb_set_addr;
  logic [DW-1:0]      wr0_data, wr1_data;
  logic [NR*AW-1:0]   rd_addr;
  logic [NR*DW-1:0]   rd_data;
  logic [NR-1:0]      rd_pending;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0]    m_mem [DEPTH];
  logic [DEPTH-1:0] m_pend;

  typedef struct packed {
    logic [NR*DW-1:0] data;
    logic [NR-1:0]    pend;
  } exp_t;

  exp_t exp_q [$];

  regfile_mp_bypass #(
    .DATA_W (DW), .ADDR_W (AW), .NUM_RD (NR), .ZERO_R0 (1)
  ) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .wr0_en      (wr0_en),
    .wr0_addr    (wr0_addr),
    .wr0_data    (wr0_data),
    .wr1_en      (wr1_en),
    .wr1_addr    (wr1_addr),
    .wr1_data    (wr1_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_pending  (rd_pending),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr)
  );

  always #5 clock = ~clock;

  function automatic exp_t model_read();
    exp_t e;
    logic w0, w1;
    logic [AW-1:0] a;
    e  = '0;
    w0 = rst_n && wr0_en && (wr0_addr != 0);
    w1 = rst_n && wr1_en && (wr1_addr != 0);
    for (int k = 0; k < NR; k++) begin
      a = rd_addr[k*AW +: AW];
      if (!rst_n || a == 0) begin
        e.data[k*DW +: DW] = '0;
        e.pend[k]          = 1'b0;
      end else if (w1 && wr1_addr == a) begin
        e.data[k*DW +: DW] = wr1_data;
        e.pend[k]          = 1'b0;
      end else if (w0 && wr0_addr == a) begin
        e.data[k*DW +: DW] = wr0_data;
        e.pend[k]          = 1'b0;
      end else begin
        e.data[k*DW +: DW] = m_mem[a];
        e.pend[k]          = m_pend[a];
      end
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_pend = '0;
  endtask

  task automatic idle();
    wr0_en = 0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 0; wr1_addr = '0; wr1_data = '0;
    sb_set_en = 0; sb_set_addr = '0;
    rd_addr = '0;
  endtask

  task automatic set_rd(input int p0, input int p1);
    rd_addr[0 +: AW]  = AW'(p0);
    rd_addr[AW +: AW] = AW'(p1);
  endtask

  task automatic drive_and_expect(input bit wait_neg);
    exp_q.push_back(model_read());
    if (wait_neg) @(negedge clock);
    else #1;
  endtask

  task automatic pop_exp(output exp_t e, output bit ok);
    ok = (exp_q.size() > 0);
    if (ok) e = exp_q.pop_front();
    else e = '0;
  endtask

  task automatic clock_edge();
    logic w0, w1;
    @(posedge clock);
    if (rst_n) begin
      w0 = wr0_en && (wr0_addr != 0);
      w1 = wr1_en && (wr1_addr != 0);
      if (w0) begin m_mem[wr0_addr] = wr0_data; m_pend[wr0_addr] = 1'b0; end
      if (w1) begin m_mem[wr1_addr] = wr1_data; m_pend[wr1_addr] = 1'b0; end
      if (sb_set_en && sb_set_addr != 0) m_pend[sb_set_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    exp_t e; bit ok;
    for (int s = 0; s < 2; s++) begin
      idle();
      set_rd(5, 0);
      if (s == 1) begin
        wr0_en = 1; wr0_addr = 5; wr0_data = 32'h1234_5678; sb_set_en = 1; sb_set_addr = 5;
      end
      drive_and_expect(1);
      pop_exp(e, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL reset: no expected entry"); end
      for (int k = 0; k < NR; k++) begin
        n_checks++;
        if (rd_data[k*DW +: DW] !== e.data[k*DW +: DW]) begin
          n_fail++; $display("FAIL reset port%0d rd_data got %h want %h", k, rd_data[k*DW +: DW], e.data[k*DW +: DW]);
        end
        n_checks++;
        if (rd_pending[k] !== e.pend[k]) begin
          n_fail++; $display("FAIL reset port%0d rd_pending got %b want %b", k, rd_pending[k], e.pend[k]);
        end
      end
      clock_edge();
    end
    idle();
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    exp_t e; bit ok;
    for (int s = 0; s < 2; s++) begin
      idle();
      set_rd(5, 6);
      if (s == 0) begin wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEAD_BEEF; end
      drive_and_expect(1);
      pop_exp(e, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL wr_rd: no expected entry"); end
      for (int k = 0; k < NR; k++) begin
        n_checks++;
        if (rd_data[k*DW +: DW] !== e.data[k*DW +: DW]) begin
          n_fail++; $display("FAIL wr_rd port%0d rd_data got %h want %h", k, rd_data[k*DW +: DW], e.data[k*DW +: DW]);
        end
        n_checks++;
        if (rd_pending[k] !== e.pend[k]) begin
          n_fail++; $display("FAIL wr_rd port%0d rd_pending got %b want %b", k, rd_pending[k], e.pend[k]);
        end
      end
      if (s == 1) begin
        n_checks++;
        if (rd_data[DW-1:0] !== 32'hDEAD_BEEF) begin
          n_fail++; $display("FAIL wr_rd_const rd_data0 got %h want deadbeef", rd_data[DW-1:0]);
        end
      end
      clock_edge();
    end
  endtask

  task automatic test_dual_write();
    exp_t e; bit ok;
    for (int s = 0; s < 2; s++) begin
      idle();
      set_rd(8, 7);
      if (s == 0) begin
        wr0_en = 1; wr0_addr = 7; wr0_data = 32'h11;
        wr1_en = 1; wr1_addr = 7; wr1_data = 32'h22;
      end
      drive_and_expect(1);
      pop_exp(e, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL dual_wr: no expected entry"); end
      for (int k = 0; k < NR; k++) begin
        n_checks++;
        if (rd_data[k*DW +: DW] !== e.data[k*DW +: DW]) begin
          n_fail++; $display("FAIL dual_wr port%0d rd_data got %h want %h", k, rd_data[k*DW +: DW], e.data[k*DW +: DW]);
        end
        n_checks++;
        if (rd_pending[k] !== e.pend[k]) begin
          n_fail++; $display("FAIL dual_wr port%0d rd_pending got %b want %b", k, rd_pending[k], e.pend[k]);
        end
      end
      n_checks++;
      if (rd_data[DW +: DW] !== 32'h22) begin
        n_fail++; $display("FAIL dual_wr_const step%0d rd_data1 got %h want 00000022", s, rd_data[DW +: DW]);
      end
      clock_edge();
    end
  endtask

  task automatic test_zero_reg();
    exp_t e; bit ok;
    for (int s = 0; s < 2; s++) begin
      idle();
      set_rd(0, 0);
      if (s == 0) begin
        wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFF_FFFF;
        wr1_en = 1; wr1_addr = 0; wr1_data = 32'hFFFF_FFFF;
        sb_set_en = 1; sb_set_addr = 0;
      end
      drive_and_expect(1);
      pop_exp(e, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL zero_reg: no expected entry"); end
      for (int k = 0; k < NR; k++) begin
        n_checks++;
        if (rd_data[k*DW +: DW] !== e.data[k*DW +: DW]) begin
          n_fail++; $display("FAIL zero_reg port%0d rd_data got %h want %h", k, rd_data[k*DW +: DW], e.data[k*DW +: DW]);
        end
        n_checks++;
        if (rd_pending[k] !== e.pend[k]) begin
          n_fail++; $display("FAIL zero_reg port%0d rd_pending got %b want %b", k, rd_pending[k], e.pend[k]);
        end
      end
      clock_edge();
    end
  endtask

  task automatic test_scoreboard();
    exp_t e; bit ok;
    for (int s = 0; s < 4; s++) begin
      idle();
      set_rd(9, 9);
      case (s)
        0: begin sb_set_en = 1; sb_set_addr = 9; end
        2: begin wr1_en = 1; wr1_addr = 9; wr1_data = 32'h42; end
        default: ;
      endcase
      drive_and_expect(1);
      pop_exp(e, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL sb: no expected entry"); end
      for (int k = 0; k < NR; k++) begin
        n_checks++;
        if (rd_data[k*DW +: DW] !== e.data[k*DW +: DW]) begin
          n_fail++; $display("FAIL sb port%0d rd_data got %h want %h", k, rd_data[k*DW +: DW], e.data[k*DW +: DW]);
        end
        n_checks++;
        if (rd_pending[k] !== e.pend[k]) begin
          n_fail++; $display("FAIL sb port%0d rd_pending got %b want %b", k, rd_pending[k], e.pend[k]);
        end
      end
      n_checks++;
      if (rd_pending[0] !== (s == 1)) begin
        n_fail++; $display("FAIL sb_const step%0d rd_pending0 got %b want %b", s, rd_pending[0], (s == 1));
      end
      clock_edge();
    end
  endtask

  task automatic test_set_clear();
    exp_t e; bit ok;
    for (int s = 0; s < 2; s++) begin
      idle();
      set_rd(3, 4);
      if (s == 0) begin
        sb_set_en = 1; sb_set_addr = 3;
        wr0_en = 1; wr0_addr = 3; wr0_data = 32'h5;
      end
      drive_and_expect(1);
      pop_exp(e, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL set_clr: no expected entry"); end
      for (int k = 0; k < NR; k++) begin
        n_checks++;
        if (rd_data[k*DW +: DW] !== e.data[k*DW +: DW]) begin
          n_fail++; $display("FAIL set_clr port%0d rd_data got %h want %h", k, rd_data[k*DW +: DW], e.data[k*DW +: DW]);
        end
        n_checks++;
        if (rd_pending[k] !== e.pend[k]) begin
          n_fail++; $display("FAIL set_clr port%0d rd_pending got %b want %b", k, rd_pending[k], e.pend[k]);
        end
      end
      if (s == 1) begin
        n_checks++;
        if (rd_data[DW-1:0] !== 32'h5 || rd_pending[0] !== 1'b1) begin
          n_fail++; $display("FAIL set_clr_const r3 got %h/%b want 00000005/1", rd_data[DW-1:0], rd_pending[0]);
        end
      end
      clock_edge();
    end
  endtask

  task automatic test_async_reset();
    exp_t e; bit ok;
    for (int s = 0; s < 4; s++) begin
      idle();
      set_rd(12, 12);
      case (s)
        0: begin wr0_en = 1; wr0_addr = 12; wr0_data = 32'hA5; sb_set_en = 1; sb_set_addr = 12; end
        2: begin
          wr1_en = 1; wr1_addr = 12; wr1_data = 32'h77;
          #2;
          rst_n = 1'b0;
          model_reset();
        end
        default: ;
      endcase
      drive_and_expect(s != 2);
      pop_exp(e, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL async_rst: no expected entry"); end
      for (int k = 0; k < NR; k++) begin
        n_checks++;
        if (rd_data[k*DW +: DW] !== e.data[k*DW +: DW]) begin
          n_fail++; $display("FAIL async_rst step%0d port%0d rd_data got %h want %h", s, k, rd_data[k*DW +: DW], e.data[k*DW +: DW]);
        end
        n_checks++;
        if (rd_pending[k] !== e.pend[k]) begin
          n_fail++; $display("FAIL async_rst step%0d port%0d rd_pending got %b want %b", s, k, rd_pending[k], e.pend[k]);
        end
      end
      clock_edge();
      if (s == 2) rst_n = 1'b1;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; bit ok;
    for (int s = 0; s < 60; s++) begin
      wr0_en      = 1'($urandom_range(0, 1));
      wr0_addr    = AW'($urandom_range(0, 7));
      wr0_data    = $urandom;
      wr1_en      = 1'($urandom_range(0, 1));
      wr1_addr    = AW'($urandom_range(0, 7));
      wr1_data    = $urandom;
      sb_set_en   = 1'($urandom_range(0, 1));
      sb_set_addr = AW'($urandom_range(0, 7));
      set_rd($urandom_range(0, 7), $urandom_range(0, 7));
      drive_and_expect(1);
      pop_exp(e, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL b2b: no expected entry"); end
      for (int k = 0; k < NR; k++) begin
        n_checks++;
        if (rd_data[k*DW +: DW] !== e.data[k*DW +: DW]) begin
          n_fail++; $display("FAIL b2b cyc%0d port%0d rd_data got %h want %h", s, k, rd_data[k*DW +: DW], e.data[k*DW +: DW]);
        end
        n_checks++;
        if (rd_pending[k] !== e.pend[k]) begin
          n_fail++; $display("FAIL b2b cyc%0d port%0d rd_pending got %b want %b", s, k, rd_pending[k], e.pend[k]);
        end
      end
      clock_edge();
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    #1;
    test_reset();
    test_write_read();
    test_dual_write();
    test_zero_reg();
    test_scoreboard();
    test_set_clear();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
